video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator with built-in test patterns for the HDMI/VGA output path.
//  Produces sync, data-enable, line/frame strobes, the pixel position and a prefetch position.
//  The prefetch position leads the display by PREFETCH clocks so a frame-buffer read port can hide its latency.
//  Test pattern selection is glitch-free: it is applied only at frame boundaries.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, clocks
//  H_SYNC    96   hsync pulse width, clocks
//  H_BP      48   horizontal back porch, clocks
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  PREFETCH  2    fetch position lead in clocks, 0..H_ACTIVE-1
//  Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*
//  Derived: XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)
// PORTS
//  i_clk_pixel   in   1   pixel clock
//  i_rst         in   1   reset, synchronous, active-high
//  i_en          in   1   1 = advance one pixel per clock; 0 = freeze counters and outputs
//  i_pattern     in   2   0 black, 1 colour bars, 2 checker, 3 gradient
//  o_hsync       out  1   horizontal sync, polarity per HS_POL
//  o_vsync       out  1   vertical sync, polarity per VS_POL
//  o_de          out  1   1 inside the active area
//  o_line_start  out  1   1-clock strobe at x == 0 of every line
//  o_frame_start out  1   1-clock strobe at x == 0, y == 0
//  o_x           out  XW  current pixel column
//  o_y           out  YW  current line
//  o_fetch_x     out  XW  column PREFETCH clocks ahead of o_x
//  o_fetch_y     out  YW  line of the prefetch position
//  o_fetch_valid out  1   1 when the prefetch position is inside the active area
//  o_r, o_g, o_b out  8   test pattern pixel; 0 when o_de == 0
// BEHAVIOUR
//  Display counters
//  - x runs 0..H_TOTAL-1. At wrap, x goes to 0 and y increments; y runs 0..V_TOTAL-1, then wraps to 0.
//  Fetch counters
//  - Same wrap rules as the display counters.
//  - Reset value is the position PREFETCH steps after (0,0).
//  Sync and data-enable
//  - hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
//  - vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
//  - de = (x < H_ACTIVE) && (y < V_ACTIVE).
//  Latency
//  - Every output is registered one clock after the counter state it describes.
//  - All outputs are mutually aligned.
//  Reset
//  - Counters go to 0 (fetch counters to their offset). The pattern register goes to 0.
//  - Outputs: sync = inactive level, de/strobes/fetch_valid = 0, x/y = 0, rgb = 0, fetch_x/y = 0.
//  - First clock after reset release: outputs describe (0,0), with o_frame_start = 1 and o_de = 1.
//  - Reset asserted mid-frame aborts the frame; no partial-line cleanup is done.
//  i_en
//  - i_en = 0 holds all counters and all output registers, strobes included, at their values.
//  - Resume continues with no skipped or repeated pixel.
//  Pattern register
//  - Loaded from i_pattern only when the counter is at (0,0) and i_en = 1.
//  - A change mid-frame takes effect on the next frame.
//  Colour bars
//  - i = x / (H_ACTIVE/8), saturating at 7.
//  - r = {8{~i[1]}}, g = {8{~i[2]}}, b = {8{~i[0]}}.
//  - Order: white, yellow, cyan, green, magenta, red, blue, black.
//  Checker: rgb = all-ones when x[5] ^ y[5], else 0.
//  Gradient: r = x[7:0], g = y[7:0], b = (x+y)[7:0]. Addition is modulo 256.
// TESTING
//  - Default params, reset release -> frame_start=1, x=0, y=0, de=1 on the first clock; next frame_start is 420000 clocks later.
//  - Default params -> hsync low for exactly 96 clocks from o_x=656; vsync low for exactly 2 lines from y=490; line period 800.
//  - Pattern 1 -> pixel at x=80 is FFFF00, x=639 is 000000, x=640 (blank) is 000000.
//  - i_pattern 1->3 at y=100 -> bars persist to end of frame; gradient from the next frame_start (x=3,y=2 -> 03,02,05).
//  - i_en low for 17 clocks at x=300 -> all outputs frozen; after resume, o_x steps 300->301.
//  - PREFETCH=2 -> fetch_x == (o_x+2) mod 800 with matching row wrap; fetch_valid at o_x=798,y=524 with fetch=(0,0).
//  - HS_POL=1, H_ACTIVE=8, small porches -> hsync high-active pulse width = H_SYNC; reset mid-line -> (0,0) next clock.

Source files
------------

// File: rtl/video_timing_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : video_timing_if                                             |
// | Brief  : Control inputs and raster/pixel outputs of the video timing |
// |          generator, bundled for the display output path.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          i_en;
  logic [1:0]    i_pattern;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic          o_line_start;
  logic          o_frame_start;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [XW-1:0] o_fetch_x;
  logic [YW-1:0] o_fetch_y;
  logic          o_fetch_valid;
  logic [7:0]    o_r;
  logic [7:0]    o_g;
  logic [7:0]    o_b;

  // Timing generator side
  modport master (
    input  i_en, i_pattern,
    output o_hsync, o_vsync, o_de, o_line_start, o_frame_start,
           o_x, o_y, o_fetch_x, o_fetch_y, o_fetch_valid, o_r, o_g, o_b
  );

  // Display / frame-buffer side
  modport slave (
    output i_en, i_pattern,
    input  o_hsync, o_vsync, o_de, o_line_start, o_frame_start,
           o_x, o_y, o_fetch_x, o_fetch_y, o_fetch_valid, o_r, o_g, o_b
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : video_timing_gen                                            |
// | Brief  : Parametrised raster timing generator with sync, DE, strobes,|
// |          pixel/prefetch positions and built-in test patterns.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PREFETCH = 2
) (
  input  wire logic       i_clk_pixel,
  input  wire logic       i_rst,
  video_timing_if.master  vt
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(c_h_total);
  localparam int YW = $clog2(c_v_total);

  localparam logic [XW-1:0] c_x_last   = XW'(c_h_total - 1);
  localparam logic [YW-1:0] c_y_last   = YW'(c_v_total - 1);
  localparam logic [XW-1:0] c_h_active = XW'(H_ACTIVE);
  localparam logic [YW-1:0] c_v_active = YW'(V_ACTIVE);
  // Sync windows are held as inclusive first/last so the end never needs H_TOTAL itself
  localparam logic [XW-1:0] c_hs_first = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] c_hs_last  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] c_vs_first = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] c_vs_last  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [XW-1:0] c_bar_w    = XW'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
  localparam logic [XW-1:0] c_pf_x     = XW'(PREFETCH);
  localparam logic          c_hs_on    = (HS_POL != 0);
  localparam logic          c_vs_on    = (VS_POL != 0);

  // Position counters (display and prefetch) and latched pattern
  logic [XW-1:0] r_x, r_fx;
  logic [YW-1:0] r_y, r_fy;
  logic [1:0]    r_pattern;

  // Output registers
  logic          r_hsync, r_vsync, r_de, r_ls, r_fs, r_fv;
  logic [XW-1:0] r_ox, r_ofx;
  logic [YW-1:0] r_oy, r_ofy;
  logic [7:0]    r_r, r_g, r_b;

  logic          w_x_wrap, w_y_wrap, w_fx_wrap, w_fy_wrap;
  logic          w_at_origin, w_de, w_hs_act, w_vs_act;
  logic [1:0]    w_pat;
  logic [XW-1:0] w_bar_q;
  logic [2:0]    w_bar;
  logic [7:0]    w_x8, w_y8;
  logic [7:0]    w_r, w_g, w_b;

  assign w_x_wrap    = (r_x == c_x_last);
  assign w_y_wrap    = (r_y == c_y_last);
  assign w_fx_wrap   = (r_fx == c_x_last);
  assign w_fy_wrap   = (r_fy == c_y_last);
  assign w_at_origin = (r_x == '0) && (r_y == '0);
  assign w_de        = (r_x < c_h_active) && (r_y < c_v_active);
  assign w_hs_act    = (r_x >= c_hs_first) && (r_x <= c_hs_last);
  assign w_vs_act    = (r_y >= c_vs_first) && (r_y <= c_vs_last);

  // The first pixel of a frame already uses the pattern being latched at that clock
  assign w_pat   = w_at_origin ? vt.i_pattern : r_pattern;
  assign w_bar_q = r_x / c_bar_w;
  assign w_bar   = (w_bar_q > XW'(7)) ? 3'd7 : w_bar_q[2:0];

  // Low byte of each coordinate, zero-extended for small rasters
  if (XW >= 8) begin : g_x8_wide
    assign w_x8 = r_x[7:0];
  end else begin : g_x8_narrow
    assign w_x8 = {{(8 - XW){1'b0}}, r_x};
  end

  if (YW >= 8) begin : g_y8_wide
    assign w_y8 = r_y[7:0];
  end else begin : g_y8_narrow
    assign w_y8 = {{(8 - YW){1'b0}}, r_y};
  end

  // Test pattern colour for the current counter position; black outside the active area
  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h00;
    if (w_de) begin
      case (w_pat)
        2'd1: begin
          w_r = {8{~w_bar[1]}};
          w_g = {8{~w_bar[2]}};
          w_b = {8{~w_bar[0]}};
        end
        2'd2: begin
          if (w_x8[5] ^ w_y8[5]) begin
            w_r = 8'hFF;
            w_g = 8'hFF;
            w_b = 8'hFF;
          end
        end
        2'd3: begin
          w_r = w_x8;
          w_g = w_y8;
          w_b = w_x8 + w_y8;
        end
        default: ;
      endcase
    end
  end

  // Advance display and prefetch counters; latch the pattern at the frame origin
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_fx      <= c_pf_x;
      r_fy      <= '0;
      r_pattern <= 2'd0;
    end else if (vt.i_en) begin
      r_x  <= w_x_wrap ? '0 : r_x + XW'(1);
      if (w_x_wrap) begin
        r_y <= w_y_wrap ? '0 : r_y + YW'(1);
      end
      r_fx <= w_fx_wrap ? '0 : r_fx + XW'(1);
      if (w_fx_wrap) begin
        r_fy <= w_fy_wrap ? '0 : r_fy + YW'(1);
      end
      if (w_at_origin) begin
        r_pattern <= vt.i_pattern;
      end
    end
  end

  // Register every output one clock after the counter state it describes
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      r_hsync <= ~c_hs_on;
      r_vsync <= ~c_vs_on;
      r_de    <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_fv    <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_ofx   <= '0;
      r_ofy   <= '0;
      r_r     <= 8'h00;
      r_g     <= 8'h00;
      r_b     <= 8'h00;
    end else if (vt.i_en) begin
      r_hsync <= w_hs_act ? c_hs_on : ~c_hs_on;
      r_vsync <= w_vs_act ? c_vs_on : ~c_vs_on;
      r_de    <= w_de;
      r_ls    <= (r_x == '0);
      r_fs    <= w_at_origin;
      r_fv    <= (r_fx < c_h_active) && (r_fy < c_v_active);
      r_ox    <= r_x;
      r_oy    <= r_y;
      r_ofx   <= r_fx;
      r_ofy   <= r_fy;
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
    end
  end

  assign vt.o_hsync       = r_hsync;
  assign vt.o_vsync       = r_vsync;
  assign vt.o_de          = r_de;
  assign vt.o_line_start  = r_ls;
  assign vt.o_frame_start = r_fs;
  assign vt.o_fetch_valid = r_fv;
  assign vt.o_x           = r_ox;
  assign vt.o_y           = r_oy;
  assign vt.o_fetch_x     = r_ofx;
  assign vt.o_fetch_y     = r_ofy;
  assign vt.o_r           = r_r;
  assign vt.o_g           = r_g;
  assign vt.o_b           = r_b;

endmodule
`default_nettype wire
